// File: rtl/partoserial.sv
// Parallel-to-serial transmitter. After reset it sends a burst of COMMA bytes for alignment,
// then sends data bytes MSB first, one byte every 8 bit clocks, or IDLE_CHAR when no byte is offered.
module partoserial #(
   parameter int unsigned SYNC_BC   = 4,
   parameter logic [7:0]  COMMA     = 8'hBC,
   parameter logic [7:0]  IDLE_CHAR = 8'h7C
) (
   input  logic       clk_32f,
   input  logic       reset_L,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       data_out,
   output logic       load_strobe,
   output logic       active
);

   typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;

   localparam logic [3:0] SYNC_TARGET = 4'(SYNC_BC);

   state_t     state_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] shreg_q;
   logic [3:0] sync_cnt_q;
   logic       data_out_q;
   logic       active_q;

   logic       load_edge;
   logic       sync_done;
   logic [7:0] next_byte;

   assign load_edge = (bit_cnt_q == 3'd0);

   // The burst is complete once SYNC_BC commas have been loaded; the edge that sees this
   // already loads the first ACTIVE byte, so no extra comma slips out.
   assign sync_done = (sync_cnt_q >= SYNC_TARGET);

   always_comb begin
      next_byte = COMMA;
      if (state_q == ST_ACTIVE || sync_done) begin
         next_byte = valid_in ? data_in : IDLE_CHAR;
      end
   end

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= ST_SYNC;
         bit_cnt_q  <= 3'd0;
         shreg_q    <= 8'h00;
         sync_cnt_q <= 4'd0;
         data_out_q <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_q + 3'd1;
         if (load_edge) begin
            shreg_q    <= next_byte;
            data_out_q <= next_byte[7];
            if (state_q == ST_SYNC) begin
               if (sync_cnt_q != 4'hF) begin
                  sync_cnt_q <= sync_cnt_q + 4'd1;
               end
               if (sync_done) begin
                  state_q  <= ST_ACTIVE;
                  active_q <= 1'b1;
               end
            end
         end else begin
            data_out_q <= shreg_q[3'd7 - bit_cnt_q];
         end
      end
   end

   assign data_out    = data_out_q;
   assign active      = active_q;
   assign load_strobe = load_edge && reset_L;

endmodule

// File: tb/tb_partoserial.sv
// Directed bench for partoserial: byte-level vector table plus hand-written reset sequences.
module tb_partoserial;

   logic       clk_32f;
   logic       reset_L;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_out;
   logic       load_strobe;
   logic       active;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic [7:0] exp_byte;
      logic       exp_active;
   } vec_t;

   vec_t vecs[19];

   partoserial #(
      .SYNC_BC   (4),
      .COMMA     (8'hBC),
      .IDLE_CHAR (8'h7C)
   ) dut (
      .clk_32f     (clk_32f),
      .reset_L     (reset_L),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .data_out    (data_out),
      .load_strobe (load_strobe),
      .active      (active)
   );

   initial clk_32f = 1'b0;
   always #5 clk_32f = ~clk_32f;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at the falling edge of a strobe cycle; returns at the falling edge of the next one.
   task automatic xfer(input int idx, input logic [7:0] d, input logic v,
                       input logic [7:0] exp_byte, input logic exp_active);
      logic [7:0] got;
      got = 8'h00;
      check($sformatf("strobe_%0d", idx), {7'd0, load_strobe}, 8'd1);
      data_in  = d;
      valid_in = v;
      for (int b = 0; b < 8; b++) begin
         @(negedge clk_32f);
         got = {got[6:0], data_out};
         if (b == 0) begin
            check($sformatf("active_%0d", idx), {7'd0, active}, {7'd0, exp_active});
            // Garbage between load edges must be ignored.
            data_in  = ~d;
            valid_in = ~v;
         end else if (b < 7) begin
            check($sformatf("nostrobe_%0d", idx), {7'd0, load_strobe}, 8'd0);
         end
      end
      check($sformatf("byte_%0d", idx), got, exp_byte);
      $display("xfer %0d: data_in=%h valid_in=%b serial=%h expect=%h active=%b",
               idx, d, v, got, exp_byte, active);
   endtask

   initial begin
      logic [7:0] part;
      n_cmp = 0;
      n_bad = 0;

      vecs[0]  = '{8'h00, 1'b0, 8'hBC, 1'b0};
      vecs[1]  = '{8'h00, 1'b0, 8'hBC, 1'b0};
      vecs[2]  = '{8'h00, 1'b0, 8'hBC, 1'b0};
      vecs[3]  = '{8'h00, 1'b0, 8'hBC, 1'b0};
      vecs[4]  = '{8'h00, 1'b0, 8'h7C, 1'b1};
      vecs[5]  = '{8'hA5, 1'b1, 8'hA5, 1'b1};
      vecs[6]  = '{8'h00, 1'b0, 8'h7C, 1'b1};
      vecs[7]  = '{8'h01, 1'b1, 8'h01, 1'b1};
      vecs[8]  = '{8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[9]  = '{8'hBC, 1'b1, 8'hBC, 1'b1};
      vecs[10] = '{8'h7C, 1'b1, 8'h7C, 1'b1};
      vecs[11] = '{8'h3C, 1'b0, 8'h7C, 1'b1};
      // After the mid-byte reset: data offered throughout SYNC is dropped.
      vecs[12] = '{8'h55, 1'b1, 8'hBC, 1'b0};
      vecs[13] = '{8'h55, 1'b1, 8'hBC, 1'b0};
      vecs[14] = '{8'h55, 1'b1, 8'hBC, 1'b0};
      vecs[15] = '{8'h55, 1'b1, 8'hBC, 1'b0};
      vecs[16] = '{8'h55, 1'b1, 8'h55, 1'b1};
      vecs[17] = '{8'h00, 1'b0, 8'h7C, 1'b1};
      vecs[18] = '{8'hC3, 1'b1, 8'hC3, 1'b1};

      reset_L  = 1'b0;
      data_in  = 8'h00;
      valid_in = 1'b0;
      repeat (5) @(negedge clk_32f);
      check("rst_data_out", {7'd0, data_out}, 8'd0);
      check("rst_active", {7'd0, active}, 8'd0);
      check("rst_load_strobe", {7'd0, load_strobe}, 8'd0);

      reset_L = 1'b1;
      #1;
      for (int i = 0; i < 12; i++) begin
         xfer(i, vecs[i].data, vecs[i].valid, vecs[i].exp_byte, vecs[i].exp_active);
      end

      // Abort a data byte part-way: three bits out, then reset mid-cycle.
      check("mid_strobe", {7'd0, load_strobe}, 8'd1);
      data_in  = 8'hA5;
      valid_in = 1'b1;
      part = 8'h00;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk_32f);
         part = {part[6:0], data_out};
      end
      check("mid_partial", part, 8'h05);
      #2;
      reset_L = 1'b0;
      #1;
      check("mid_rst_data_out", {7'd0, data_out}, 8'd0);
      check("mid_rst_active", {7'd0, active}, 8'd0);
      check("mid_rst_load_strobe", {7'd0, load_strobe}, 8'd0);
      repeat (2) @(negedge clk_32f);
      data_in  = 8'h55;
      valid_in = 1'b1;
      reset_L  = 1'b1;
      #1;
      for (int i = 12; i < 19; i++) begin
         xfer(i, vecs[i].data, vecs[i].valid, vecs[i].exp_byte, vecs[i].exp_active);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
